// File: rtl/prim_ram_2p_pipe_pkg.sv
// prim_ram_2p_pipe_pkg: collision policy and latency limits for prim_ram_2p_pipe
package prim_ram_2p_pipe_pkg;
    typedef enum logic {COLL_WRITE_FIRST, COLL_READ_FIRST} coll_mode_e;
    localparam int MaxReadLatency = 2;
endpackage

// File: rtl/prim_ram_2p_pkg.sv
// prim_ram_2p_pkg: shared configuration type for two-port RAM primitives
package prim_ram_2p_pkg;
    typedef struct packed {
        logic       cfg_en;
        logic [3:0] cfg;
    } ram_2p_cfg_t;
endpackage

// File: rtl/prim_ram_2p_pipe_rdport.sv
// prim_ram_2p_pipe_rdport: per-port read pipeline, one or two stages, holds rdata between reads
module prim_ram_2p_pipe_rdport
    import prim_ram_2p_pipe_pkg::*;
#(
    parameter int Width       = 32,
    parameter int ReadLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] rdata_o,
    output logic             rvalid_o
);
    logic             v1_q;
    logic [Width-1:0] d1_q;

    if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_lat
        $error("ReadLatency must be 1 or 2");
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_i;
            if (rd_i) d1_q <= data_i;
        end
    end

    if (ReadLatency == 2) begin : g_lat2
        logic             v2_q;
        logic [Width-1:0] d2_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) d2_q <= d1_q;
            end
        end
        assign rvalid_o = v2_q;
        assign rdata_o  = d2_q;
    end else begin : g_lat1
        assign rvalid_o = v1_q;
        assign rdata_o  = d1_q;
    end
endmodule

// File: rtl/prim_ram_2p_pipe.sv
// prim_ram_2p_pipe: true two-port RAM with masked writes, collision policy and pipelined reads.
// Define PRIM_RAM_2P_PIPE_COLL_CNT_EN to add a saturating collision counter.
module prim_ram_2p_pipe
    import prim_ram_2p_pkg::*;
    import prim_ram_2p_pipe_pkg::*;
#(
    parameter int         Width           = 32,
    parameter int         Depth           = 128,
    parameter int         DataBitsPerMask = 8,
    parameter int         ReadLatency     = 1,
    parameter coll_mode_e CollisionMode   = COLL_WRITE_FIRST,
    localparam int        Aw              = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic              a_write_i,
    input  logic [Aw-1:0]     a_addr_i,
    input  logic [Width-1:0]  a_wdata_i,
    input  logic [Width-1:0]  a_wmask_i,
    output logic [Width-1:0]  a_rdata_o,
    output logic              a_rvalid_o,
    input  logic              b_req_i,
    input  logic              b_write_i,
    input  logic [Aw-1:0]     b_addr_i,
    input  logic [Width-1:0]  b_wdata_i,
    input  logic [Width-1:0]  b_wmask_i,
    output logic [Width-1:0]  b_rdata_o,
    output logic              b_rvalid_o,
    output logic              coll_o,
`ifdef PRIM_RAM_2P_PIPE_COLL_CNT_EN
    output logic [15:0]       coll_cnt_o,
    input  logic              coll_cnt_clr_i,
`endif
    input  ram_2p_cfg_t       cfg_i
);
    localparam int Groups = Width / DataBitsPerMask;

    logic [Width-1:0]  mem [Depth];
    logic              a_wr, b_wr, same;
    logic [Groups-1:0] a_gen, b_gen;
    logic [Width-1:0]  a_old, b_old, a_word, b_word;
    logic              cfg_unused;

    if (Width % DataBitsPerMask != 0) begin : g_bad_mask
        $error("Width must be a multiple of DataBitsPerMask");
    end

    function automatic logic [Width-1:0] merge(input logic [Width-1:0] old, data,
                                               input logic [Groups-1:0] en);
        logic [Width-1:0] r;
        r = old;
        for (int g = 0; g < Groups; g++)
            if (en[g]) r[g*DataBitsPerMask +: DataBitsPerMask] = data[g*DataBitsPerMask +: DataBitsPerMask];
        return r;
    endfunction

    // A mask group is written only when every bit of it is enabled
    for (genvar g = 0; g < Groups; g++) begin : g_gen
        assign a_gen[g] = &a_wmask_i[g*DataBitsPerMask +: DataBitsPerMask];
        assign b_gen[g] = &b_wmask_i[g*DataBitsPerMask +: DataBitsPerMask];
    end

    assign a_wr   = a_req_i & a_write_i & ~rst_i;
    assign b_wr   = b_req_i & b_write_i & ~rst_i;
    assign same   = a_addr_i == b_addr_i;
    assign a_old  = mem[a_addr_i];
    assign b_old  = mem[b_addr_i];
    assign a_word = (CollisionMode == COLL_WRITE_FIRST && b_wr && same) ? merge(a_old, b_wdata_i, b_gen) : a_old;
    assign b_word = (CollisionMode == COLL_WRITE_FIRST && a_wr && same) ? merge(b_old, a_wdata_i, a_gen) : b_old;

    // Port A is assigned last so its groups win a same-address write-write collision
    always_ff @(posedge clk_i) begin
        for (int g = 0; g < Groups; g++) begin
            if (b_wr && b_gen[g]) mem[b_addr_i][g*DataBitsPerMask +: DataBitsPerMask] <= b_wdata_i[g*DataBitsPerMask +: DataBitsPerMask];
            if (a_wr && a_gen[g]) mem[a_addr_i][g*DataBitsPerMask +: DataBitsPerMask] <= a_wdata_i[g*DataBitsPerMask +: DataBitsPerMask];
        end
    end

    always_ff @(posedge clk_i) begin
        coll_o <= rst_i ? 1'b0 : a_req_i & b_req_i & same & (a_write_i | b_write_i);
    end

    prim_ram_2p_pipe_rdport #(.Width(Width), .ReadLatency(ReadLatency)) u_rd_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_i     (a_req_i & ~a_write_i),
        .data_i   (a_word),
        .rdata_o  (a_rdata_o),
        .rvalid_o (a_rvalid_o)
    );

    prim_ram_2p_pipe_rdport #(.Width(Width), .ReadLatency(ReadLatency)) u_rd_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_i     (b_req_i & ~b_write_i),
        .data_i   (b_word),
        .rdata_o  (b_rdata_o),
        .rvalid_o (b_rvalid_o)
    );

`ifdef PRIM_RAM_2P_PIPE_COLL_CNT_EN
    always_ff @(posedge clk_i) begin
        coll_cnt_o <= (rst_i || coll_cnt_clr_i) ? 16'h0 : (coll_o && coll_cnt_o != 16'hFFFF) ? coll_cnt_o + 16'h1 : coll_cnt_o;
    end
`endif

    assign cfg_unused = ^cfg_i;
endmodule

// File: tb/tb_prim_ram_2p_pipe.sv
// tb_prim_ram_2p_pipe: three instances (L1 write-first, L1 read-first, L2 write-first) on shared
// stimulus, checked every cycle against a cycle-scheduled memory model plus literal expectations.
module tb_prim_ram_2p_pipe;
    import prim_ram_2p_pkg::*;
    import prim_ram_2p_pipe_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        a_req, a_write, b_req, b_write;
    logic [6:0]  a_addr, b_addr;
    logic [31:0] a_wdata, a_wmask, b_wdata, b_wmask;
    logic [31:0] rd [6];
    logic        rv [6];
    logic        co [3];
    ram_2p_cfg_t cfg;
`ifdef PRIM_RAM_2P_PIPE_COLL_CNT_EN
    logic [15:0] cnt [3];
    logic        clr;
`endif
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // Instance d: ports a/b map to rd/rv index 2d / 2d+1
    for (genvar d = 0; d < 3; d++) begin : g_dut
        prim_ram_2p_pipe #(
            .ReadLatency   (d == 2 ? 2 : 1),
            .CollisionMode (d == 1 ? COLL_READ_FIRST : COLL_WRITE_FIRST)
        ) dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .a_req_i    (a_req),
            .a_write_i  (a_write),
            .a_addr_i   (a_addr),
            .a_wdata_i  (a_wdata),
            .a_wmask_i  (a_wmask),
            .a_rdata_o  (rd[2*d]),
            .a_rvalid_o (rv[2*d]),
            .b_req_i    (b_req),
            .b_write_i  (b_write),
            .b_addr_i   (b_addr),
            .b_wdata_i  (b_wdata),
            .b_wmask_i  (b_wmask),
            .b_rdata_o  (rd[2*d+1]),
            .b_rvalid_o (rv[2*d+1]),
            .coll_o     (co[d]),
`ifdef PRIM_RAM_2P_PIPE_COLL_CNT_EN
            .coll_cnt_o     (cnt[d]),
            .coll_cnt_clr_i (clr),
`endif
            .cfg_i      (cfg)
        );
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, data, mask);
        logic [31:0] r;
        r = old;
        for (int g = 0; g < 4; g++) if (&mask[8*g +: 8]) r[8*g +: 8] = data[8*g +: 8];
        return r;
    endfunction

    // Model: reads are booked into a slot for the edge they complete on; outputs hold between completions
    logic [31:0] mmem [128];
    logic        sv [6][4];
    logic [31:0] sd [6][4];
    logic        ev [6];
    logic [31:0] ed [6];
    logic        ec;
    int          k = 0;
    bit          live = 0;

    always @(negedge clk) begin
        logic [31:0] ao, bo;
        logic        same;
        int          lat, s;
        if (live) begin
            for (int p = 0; p < 6; p++) begin
                cmp($sformatf("model rvalid[%0d]", p), 32'(rv[p]), 32'(ev[p]));
                cmp($sformatf("model rdata[%0d]", p), rd[p], ed[p]);
            end
            for (int d = 0; d < 3; d++) cmp($sformatf("model coll[%0d]", d), 32'(co[d]), 32'(ec));
        end
        if (rst) begin
            live = 1;
            ec = 0;
            for (int p = 0; p < 6; p++) begin
                ev[p] = 0;
                ed[p] = 0;
                for (int j = 0; j < 4; j++) sv[p][j] = 0;
            end
        end else begin
            k++;
            ao = mmem[a_addr];
            bo = mmem[b_addr];
            same = a_addr == b_addr;
            ec = a_req && b_req && same && (a_write || b_write);
            for (int d = 0; d < 3; d++) begin
                lat = d == 2 ? 2 : 1;
                s = (k + lat - 1) % 4;
                if (a_req && !a_write) begin
                    sv[2*d][s] = 1;
                    sd[2*d][s] = (d != 1 && b_req && b_write && same) ? merge(ao, b_wdata, b_wmask) : ao;
                end
                if (b_req && !b_write) begin
                    sv[2*d+1][s] = 1;
                    sd[2*d+1][s] = (d != 1 && a_req && a_write && same) ? merge(bo, a_wdata, a_wmask) : bo;
                end
                for (int p = 2*d; p < 2*d + 2; p++) begin
                    ev[p] = sv[p][k%4];
                    if (sv[p][k%4]) ed[p] = sd[p][k%4];
                    sv[p][k%4] = 0;
                end
            end
            if (b_req && b_write) mmem[b_addr] = merge(mmem[b_addr], b_wdata, b_wmask);
            if (a_req && a_write) mmem[a_addr] = merge(mmem[a_addr], a_wdata, a_wmask);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        a_req = 0; a_write = 0; b_req = 0; b_write = 0;
    endtask

    task automatic wr_a(input logic [6:0] ad, input logic [31:0] dt, mk);
        a_req = 1; a_write = 1; a_addr = ad; a_wdata = dt; a_wmask = mk;
    endtask

    task automatic wr_b(input logic [6:0] ad, input logic [31:0] dt, mk);
        b_req = 1; b_write = 1; b_addr = ad; b_wdata = dt; b_wmask = mk;
    endtask

    task automatic rd_a(input logic [6:0] ad);
        a_req = 1; a_write = 0; a_addr = ad;
    endtask

    task automatic rd_b(input logic [6:0] ad);
        b_req = 1; b_write = 0; b_addr = ad;
    endtask

    initial begin
        cfg = '0;
        idle();
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0; a_wmask = 0; b_wmask = 0;
`ifdef PRIM_RAM_2P_PIPE_COLL_CNT_EN
        clr = 0;
`endif
        repeat (3) tick();
        rst = 0;
        cmp("reset a_rvalid", 32'(rv[0]), 0);
        cmp("reset b_rdata", rd[1], 0);

        wr_a(5, 32'hDEADBEEF, 32'hFFFFFFFF); tick();
        idle(); rd_b(5); tick();
        cmp("b_rdata @5", rd[1], 32'hDEADBEEF);
        cmp("b_rvalid @5", 32'(rv[1]), 1);
        cmp("lat2 b_rvalid early", 32'(rv[5]), 0);
        idle(); tick();
        cmp("b_rvalid one cycle", 32'(rv[1]), 0);
        cmp("b_rdata hold", rd[1], 32'hDEADBEEF);
        cmp("lat2 b_rvalid", 32'(rv[5]), 1);
        cmp("lat2 b_rdata", rd[5], 32'hDEADBEEF);

        wr_a(7, 32'h11223344, 32'hFFFFFFFF); tick();
        wr_a(7, 32'hAABBCCDD, 32'h0000FFFF); rd_b(7); tick();
        cmp("rw write-first", rd[1], 32'h1122CCDD);
        cmp("rw read-first", rd[3], 32'h11223344);
        cmp("rw coll pulse", 32'(co[0]), 1);
        idle(); tick();
        cmp("rw coll drop", 32'(co[0]), 0);
        cmp("rw lat2 write-first", rd[5], 32'h1122CCDD);
        rd_a(7); tick();
        cmp("rw merged word", rd[2], 32'h1122CCDD);

        wr_a(3, 32'h000000AA, 32'h000000FF); wr_b(3, 32'hBBBBBB00, 32'hFFFFFFFF); tick();
        cmp("ww coll pulse", 32'(co[0]), 1);
        idle(); tick();
        cmp("ww coll once", 32'(co[0]), 0);
        rd_a(3); tick();
        cmp("ww merged", rd[0], 32'hBBBBBBAA);

        wr_a(10, 32'h0, 32'hFFFFFFFF); tick();
        wr_a(10, 32'h12345678, 32'h000001FF); tick();
        rd_a(10); tick();
        cmp("partial group", rd[0], 32'h00000078);
        idle();

        for (int i = 0; i < 10; i++) begin
            wr_a(7'(i), 32'h100 + i, 32'hFFFFFFFF); tick();
        end
        for (int i = 0; i < 12; i++) begin
            idle();
            if (i < 10) begin rd_a(7'(i)); rd_b(7'(i)); end
            tick();
            cmp($sformatf("stream rvalid %0d", i), 32'(rv[4]), 32'(i >= 1 && i <= 10));
            if (i >= 1 && i <= 10) cmp($sformatf("stream rdata %0d", i), rd[4], 32'h100 + i - 1);
            cmp($sformatf("stream rr coll %0d", i), 32'(co[2]), 0);
        end

        rd_a(5); tick();
        idle(); rst = 1; wr_a(5, 32'hFFFFFFFF, 32'hFFFFFFFF); tick();
        for (int p = 0; p < 6; p++) begin
            cmp($sformatf("rst rdata[%0d]", p), rd[p], 0);
            cmp($sformatf("rst rvalid[%0d]", p), 32'(rv[p]), 0);
        end
        rst = 0; idle(); tick();
        cmp("rst discard lat2", 32'(rv[4]), 0);
        rd_a(5); tick();
        cmp("rst preserves mem", rd[0], 32'h105);
        idle(); tick();

`ifdef PRIM_RAM_2P_PIPE_COLL_CNT_EN
        wr_a(20, 32'h1, 32'hFFFFFFFF); rd_b(20);
        repeat (70000) tick();
        idle(); tick(); tick();
        for (int d = 0; d < 3; d++) cmp($sformatf("coll_cnt sat[%0d]", d), 32'(cnt[d]), 32'hFFFF);
        wr_a(20, 32'h2, 32'hFFFFFFFF); rd_b(20); tick();
        idle(); clr = 1; tick();
        clr = 0;
        for (int d = 0; d < 3; d++) cmp($sformatf("coll_cnt clr[%0d]", d), 32'(cnt[d]), 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prim_ram_2p_pipe.md
PRIM_RAM_2P_PIPE -- requirements
Module: prim_ram_2p_pipe

Interface
REQ-001 SHALL have parameter Width, 32, data bits per word.
REQ-002 SHALL have parameter Depth, 128, words; Aw = $clog2(Depth) is derived.
REQ-003 SHALL have parameter DataBitsPerMask, 8, data bits per internal mask bit; Width divisible by it.
REQ-004 SHALL have parameter ReadLatency, 1, request-to-rdata cycles; legal values 1 or 2.
REQ-005 SHALL have parameter CollisionMode, COLL_WRITE_FIRST, same-address read/write policy (COLL_WRITE_FIRST or COLL_READ_FIRST).
REQ-006 SHALL have ports clk_i in 1 (sole clock); rst_i in 1 (reset, synchronous, active-high).
REQ-007 SHALL have ports a_req_i in 1; a_write_i in 1; a_addr_i in Aw; a_wdata_i in Width; a_wmask_i in Width (full bit mask).
REQ-008 SHALL have ports a_rdata_o out Width; a_rvalid_o out 1 (a_rdata_o valid this cycle).
REQ-009 SHALL have port B signals b_req_i, b_write_i, b_addr_i, b_wdata_i, b_wmask_i, b_rdata_o, b_rvalid_o, identical to port A.
REQ-010 SHALL have port coll_o out 1, pulse: same-address collision accepted this cycle.
REQ-011 SHALL have ports cfg_i in ram_2p_cfg_t (unused, XOR-reduced into an unused signal).

Function
REQ-012 SHALL treat every request as accepted in its cycle; there is no backpressure.
REQ-013 SHALL write on req&write: update mask group k only when all DataBitsPerMask bits of group k in wmask are 1.
REQ-014 SHALL, on read req at cycle N, assert rvalid and present rdata at cycle N+ReadLatency, then hold rdata until the next read on that port.
REQ-015 SHALL deassert rvalid whenever no read completes in that cycle; a write never raises rvalid.
REQ-016 SHALL sustain back-to-back reads every cycle on each port with no bubbles, for both latencies.
REQ-017 SHALL resolve a write-write collision (both ports write the same address, same cycle) per mask group: port A's enabled groups win; port-B-only groups take B data.
REQ-018 SHALL, on read/write to the same address in one cycle with COLL_WRITE_FIRST, return the merged new word (masked new data, old data elsewhere).
REQ-019 SHALL, on the same collision with COLL_READ_FIRST, return the old word.
REQ-020 SHALL assert coll_o for exactly one cycle, the cycle after any same-address collision (ww or rw); rr is not a collision.
REQ-021 SHALL give ReadLatency=2 exactly one extra output register stage on rdata/rvalid; the collision policy is unchanged.

Reset
REQ-022 SHALL clear a_rvalid_o, b_rvalid_o, coll_o, a_rdata_o and b_rdata_o to 0 in the cycle after rst_i is sampled high.
REQ-023 SHALL discard reads in flight when rst_i is asserted; no rvalid is generated for them after reset.
REQ-024 SHALL leave memory contents unchanged by reset; requests presented while rst_i is high are ignored (no write).

Configuration
REQ-025 SHALL, with PRIM_RAM_2P_PIPE_COLL_CNT_EN defined, add an output coll_cnt_o (16 bit) and an input coll_cnt_clr_i (1 bit).
REQ-026 SHALL make coll_cnt_o increment on each coll_o pulse and saturate at 16'hFFFF.
REQ-027 SHALL zero coll_cnt_o on rst_i or coll_cnt_clr_i; clear takes priority over a simultaneous increment.
REQ-028 SHALL, without the macro, have neither port nor counter logic; all other behaviour is identical.

Structure
REQ-029 SHALL place the coll_mode_e enum (COLL_WRITE_FIRST, COLL_READ_FIRST) and the MaxReadLatency=2 constant in package prim_ram_2p_pipe_pkg; ram_2p_cfg_t stays in prim_ram_2p_pkg.
REQ-030 SHALL implement each port's output pipeline (latency stages, rvalid, hold) in sub-module prim_ram_2p_pipe_rdport, instantiated twice.
REQ-031 SHALL implement memory writes in a single always_ff with the priority of REQ-017, so the array has no dual drivers.

Verification
REQ-032 SHALL cover: A writes 0xDEADBEEF @5, mask all ones; B reads @5 next cycle, ReadLatency=1 -> b_rdata_o=0xDEADBEEF with b_rvalid_o high for exactly one cycle.
REQ-033 SHALL cover: @7 = 0x11223344; A writes 0xAABBCCDD mask 0x0000FFFF while B reads @7, WRITE_FIRST -> 0x1122CCDD, coll_o pulses; READ_FIRST -> 0x11223344.
REQ-034 SHALL cover: A writes 0x000000AA mask 0x000000FF and B writes 0xBBBBBB00 mask 0xFFFFFFFF to @3 in the same cycle -> a later read gives 0xBBBBBBAA, coll_o pulses once.
REQ-035 SHALL cover: ReadLatency=2, A reads @0..@9 on consecutive cycles -> ten consecutive rvalid cycles starting 2 cycles after the first request, data in order.
REQ-036 SHALL cover: rst_i asserted one cycle after a read request with ReadLatency=2 -> no rvalid for that read, all outputs 0, memory preserved.
REQ-037 SHALL cover, with the macro defined: 70000 forced collisions -> coll_cnt_o=0xFFFF; coll_cnt_clr_i coinciding with a collision -> coll_cnt_o=0.
